// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_regfile_core.sv
// rtl/axil_regfile_core.sv - register storage, byte-strobe update, RO status mux and write pulses
module axil_regfile_core
  import axi_lite_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   ADDR_W    = 4,
  parameter int                   NUM_REGS  = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic [DATA_W/8-1:0]          i_wr_strb,
  output axi_resp_t                    o_wr_resp,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [DATA_W-1:0]            o_rd_data,
  output axi_resp_t                    o_rd_resp,
  input  logic [NUM_REGS*DATA_W-1:0]   i_status,
  output logic [NUM_REGS*DATA_W-1:0]   o_reg_q,
  output logic [NUM_REGS-1:0]          o_wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic [ADDR_W-1:0]   w_wr_word;
  logic [ADDR_W-1:0]   w_rd_word;
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_rd_hit;
  logic [NUM_REGS-1:0] w_wr_ok;
  logic                w_any_strb;
  logic                w_unused_status;

  assign w_wr_word  = i_wr_addr >> LSB;
  assign w_rd_word  = i_rd_addr >> LSB;
  assign w_any_strb = |i_wr_strb;

  always_comb begin
    w_wr_hit = '0;
    w_rd_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_wr_hit[i] = (w_wr_word == ADDR_W'(i));
      w_rd_hit[i] = (w_rd_word == ADDR_W'(i));
    end
  end

  // Only in-range RW targets accept writes; everything else answers SLVERR.
  assign w_wr_ok   = w_wr_hit & ~RO_MASK;
  assign o_wr_resp = (|w_wr_ok) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= i_wr_en && w_wr_ok[i] && w_any_strb;
        if (i_wr_en && w_wr_ok[i]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (i_wr_strb[b]) begin
              r_regs[i][b*8 +: 8] <= i_wr_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_hit[i]) begin
        o_rd_resp = RESP_OKAY;
        o_rd_data = RO_MASK[i] ? i_status[i*DATA_W +: DATA_W] : r_regs[i];
      end
    end
  end

  always_comb begin
    o_reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign o_wr_pulse      = r_wr_pulse;
  // Status slices of RW registers are intentionally ignored.
  assign w_unused_status = ^{1'b0, i_status};

endmodule

// File: rtl/axil_regfile.sv
// rtl/axil_regfile.sv - AXI4-Lite slave front end: AW/W hold, B and R channel handshakes
module axil_regfile
  import axi_lite_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   ADDR_W    = 4,
  parameter int                   NUM_REGS  = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [ADDR_W-1:0]           s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [DATA_W-1:0]           s_axi_wdata,
  input  logic [DATA_W/8-1:0]         s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [ADDR_W-1:0]           s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [DATA_W-1:0]           s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  input  logic [NUM_REGS*DATA_W-1:0]  status_i,
  output logic [NUM_REGS*DATA_W-1:0]  reg_q,
  output logic [NUM_REGS-1:0]         wr_pulse
);

  localparam int STRB_W = DATA_W / 8;

  logic               r_ready_en;
  logic               r_aw_held;
  logic               r_w_held;
  logic [ADDR_W-1:0]  r_awaddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [STRB_W-1:0]  r_wstrb;
  logic               r_bvalid;
  axi_resp_t          r_bresp;
  logic               r_rvalid;
  axi_resp_t          r_rresp;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_commit;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;
  logic [STRB_W-1:0]  w_wr_strb;
  axi_resp_t          w_wr_resp;
  logic [DATA_W-1:0]  w_rd_data;
  axi_resp_t          w_rd_resp;

  // r_ready_en keeps every ready low until the first edge after reset release.
  assign s_axi_awready = r_ready_en && !r_aw_held && !r_bvalid;
  assign s_axi_wready  = r_ready_en && !r_w_held && !r_bvalid;
  assign s_axi_arready = r_ready_en && !r_rvalid;

  assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_w_hs   = s_axi_wvalid && s_axi_wready;
  assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
  assign w_wr_data = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wr_strb = r_w_held  ? r_wstrb  : s_axi_wstrb;

  axil_regfile_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_REGS  (NUM_REGS),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_core (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .i_wr_en    (w_commit),
    .i_wr_addr  (w_wr_addr),
    .i_wr_data  (w_wr_data),
    .i_wr_strb  (w_wr_strb),
    .o_wr_resp  (w_wr_resp),
    .i_rd_addr  (s_axi_araddr),
    .o_rd_data  (w_rd_data),
    .o_rd_resp  (w_rd_resp),
    .i_status   (status_i),
    .o_reg_q    (reg_q),
    .o_wr_pulse (wr_pulse)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_ready_en <= 1'b1;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi_wdata;
          r_wstrb  <= s_axi_wstrb;
        end
        if (r_bvalid && s_axi_bready) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_axil_regfile.sv
// tb/tb_axil_regfile.sv - directed and randomized checks of axil_regfile against a register model
module tb_axil_regfile;

  logic         clk = 1'b0;
  logic         s_axi_aresetn = 1'b0;
  logic [4:0]   s_axi_awaddr = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata = '0;
  logic [3:0]   s_axi_wstrb = '0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b1;
  logic [4:0]   s_axi_araddr = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b1;
  logic [127:0] status_i = '0;
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_regs [4];

  always #5 clk = ~clk;

  axil_regfile #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .NUM_REGS  (4),
    .RO_MASK   (4'b1000),
    .RESET_VAL (32'h0)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .status_i      (status_i),
    .reg_q         (reg_q),
    .wr_pulse      (wr_pulse)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: word index = addr/4; index 3 is read-only status, 4+ is out of range.
  function automatic bit model_writable(input logic [4:0] addr);
    int idx = int'(addr) / 4;
    return (idx < 3);
  endfunction

  function automatic logic [127:0] model_reg_q();
    return {32'h0, m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_at, input int w_at, input string tag);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire;
    bit w_fire;
    int c = 0;
    int idx = int'(addr) / 4;
    logic [1:0] exp_resp = 2'b10;
    logic [3:0] exp_pulse = 4'h0;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      s_axi_awvalid = (c >= aw_at) && !aw_done;
      s_axi_wvalid  = (c >= w_at) && !w_done;
      @(negedge clk);
      aw_fire = s_axi_awvalid && s_axi_awready;
      w_fire  = s_axi_wvalid && s_axi_wready;
      step();
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      if (!(aw_done && w_done)) check({tag, "_early_bvalid"}, s_axi_bvalid, 1'b0);
      c++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    check({tag, "_handshake"}, aw_done && w_done, 1'b1);
    if (model_writable(addr)) begin
      exp_resp = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      if (strb != 4'h0) exp_pulse = 4'(1 << idx);
    end
    check({tag, "_bvalid"}, s_axi_bvalid, 1'b1);
    check({tag, "_bresp"}, s_axi_bresp, exp_resp);
    check({tag, "_pulse"}, wr_pulse, exp_pulse);
    check({tag, "_reg_q"}, reg_q, model_reg_q());
    if (s_axi_bready) begin
      step();
      check({tag, "_bvalid_clr"}, s_axi_bvalid, 1'b0);
      check({tag, "_pulse_clr"}, wr_pulse, 4'h0);
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input int hold, input string tag);
    int idx = int'(addr) / 4;
    logic [31:0] exp_data = 32'h0;
    logic [1:0] exp_resp = 2'b10;
    bit fire = 0;
    int c = 0;
    if (idx < 3) begin
      exp_data = m_regs[idx];
      exp_resp = 2'b00;
    end else if (idx == 3) begin
      exp_data = status_i[127:96];
      exp_resp = 2'b00;
    end
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = (hold == 0);
    while (!fire && c < 20) begin
      @(negedge clk);
      fire = s_axi_arready;
      step();
      c++;
    end
    s_axi_arvalid = 1'b0;
    check({tag, "_ar_handshake"}, fire, 1'b1);
    check({tag, "_rvalid"}, s_axi_rvalid, 1'b1);
    check({tag, "_rdata"}, s_axi_rdata, exp_data);
    check({tag, "_rresp"}, s_axi_rresp, exp_resp);
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, "_rvalid_held"}, s_axi_rvalid, 1'b1);
      check({tag, "_rdata_held"}, s_axi_rdata, exp_data);
    end
    s_axi_rready = 1'b1;
    step();
    check({tag, "_rvalid_clr"}, s_axi_rvalid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    repeat (3) @(posedge clk);

    // Reset release: readies low for the first cycle, high after.
    @(negedge clk);
    s_axi_aresetn = 1'b1;
    #1;
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid, wr_pulse}, 6'h0);
    check("rst_readies_first", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    check("rst_reg_q", reg_q, 128'h0);
    step();
    check("rst_readies_after", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    do_read(5'h00, 0, "rst_rd0");
    do_read(5'h04, 0, "rst_rd4");
    do_read(5'h08, 0, "rst_rd8");

    do_write(5'h04, 32'hDEADBEEF, 4'hF, 0, 3, "aw_first");
    check("aw_first_value", reg_q[63:32], 32'hDEADBEEF);
    do_read(5'h04, 0, "aw_first_rd");

    do_write(5'h00, 32'h11223344, 4'hF, 0, 0, "same_cycle");
    do_write(5'h00, 32'hAABBCCDD, 4'h3, 2, 0, "w_first");
    check("w_first_value", reg_q[31:0], 32'h1122CCDD);

    do_write(5'h0C, 32'h55555555, 4'hF, 0, 0, "ro_wr");
    status_i[127:96] = 32'hCAFEF00D;
    do_read(5'h0C, 0, "ro_rd");
    do_write(5'h10, 32'h77777777, 4'hF, 1, 0, "oor_wr");
    do_read(5'h10, 0, "oor_rd");
    do_write(5'h08, 32'h99999999, 4'h0, 0, 0, "zero_strb");

    // B backpressure: response and readies frozen while bready is low.
    s_axi_bready = 1'b0;
    do_write(5'h08, 32'h0BADF00D, 4'hF, 0, 0, "bp");
    s_axi_awaddr  = 5'h00;
    s_axi_awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_bvalid_held", s_axi_bvalid, 1'b1);
      check("bp_bresp_held", s_axi_bresp, 2'b00);
      check("bp_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
    end
    s_axi_awvalid = 1'b0;
    s_axi_bready  = 1'b1;
    step();
    check("bp_bvalid_clr", s_axi_bvalid, 1'b0);
    check("bp_awready_back", s_axi_awready, 1'b1);
    do_write(5'h00, 32'h01020304, 4'hF, 0, 1, "bp_next");
    do_read(5'h08, 3, "r_bp");

    // Read and write committing on the same edge to register 1.
    s_axi_awaddr = 5'h04; s_axi_wdata = 32'h5A5A5A5A; s_axi_wstrb = 4'hF;
    s_axi_araddr = 5'h04;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("rw_same_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("rw_same_rdata_old", s_axi_rdata, m_regs[1]);
    m_regs[1] = 32'h5A5A5A5A;
    check("rw_same_bvalid", s_axi_bvalid, 1'b1);
    check("rw_same_reg_q", reg_q, model_reg_q());
    step();

    for (int n = 0; n < 40; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 23));
      status_i = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
      else
        do_read(a, $urandom_range(0, 2), "rnd_rd");
    end

    // Async reset with AW held: nothing must commit after release.
    s_axi_awaddr  = 5'h08;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    check("ar_aw_ready", s_axi_awready, 1'b1);
    step();
    s_axi_awvalid = 1'b0;
    #2;
    s_axi_aresetn = 1'b0;
    #1;
    check("ar_async_clear", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wr_pulse},
          9'h0);
    check("ar_async_reg_q", reg_q, 128'h0);
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_axi_aresetn = 1'b1;
    step();
    do_read(5'h08, 0, "ar_rd2");
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ar_no_bvalid", s_axi_bvalid, 1'b0);
    end
    s_axi_wvalid = 1'b0;
    check("ar_reg_q", reg_q, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
